pyrx_word_packer: RTL and testbench

PYRX_WORD_PACKER -- requirements
Module: pyrx_wordpack

---
 rtl/pyrx_pkg.sv | 15 +
 rtl/pyrx_word_packer.sv | 135 +++++++++++++
 tb/tb_pyrx_word_packer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pyrx_pkg.sv
// rtl/pyrx_pkg.sv - shared state encoding and sizing defaults for the payload word packer
package pyrx_pkg;

    localparam int BUF_WORDS_DEF = 256;
    localparam int ADDR_W_DEF    = 8;

    localparam logic [9:0] BYTECNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_FLUSH = 2'd2
    } pyrx_state_e;

endpackage

// File: rtl/pyrx_word_packer.sv
// rtl/pyrx_word_packer.sv - packs decoded payload bytes little-endian into 32-bit rx buffer words
module pyrx_word_packer
    import pyrx_pkg::*;
#(
    parameter int BUF_WORDS = BUF_WORDS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk_6M,
    input  logic              rstz,
    input  logic              py_start_p,
    input  logic [7:0]        py_byte,
    input  logic              py_byte_valid_p,
    input  logic              py_end_p,
    output logic [ADDR_W-1:0] lnctrl_addr,
    output logic [31:0]       lnctrl_din,
    output logic              lnctrl_we,
    output logic [9:0]        py_bytecnt,
    output logic              py_done_p,
    output logic              py_ovf
);

    pyrx_state_e       r_state;
    pyrx_state_e       w_state_nxt;
    logic [31:0]       r_pack;
    logic [1:0]        r_lane;
    logic [ADDR_W:0]   r_addr;
    logic [31:0]       r_din;
    logic              r_we;
    logic [9:0]        r_bytecnt;
    logic              r_done;
    logic              r_ovf;

    logic              w_in_pack;
    logic              w_full;
    logic              w_take;
    logic              w_drop;
    logic              w_end;
    logic              w_word_done;
    logic              w_flush;
    logic [1:0]        w_lane_nxt;
    logic [31:0]       w_pack_merged;

    // A write in flight to the last word already counts as consuming it.
    assign w_full      = r_addr[ADDR_W] |
                         (r_we & (r_addr[ADDR_W-1:0] == ADDR_W'(BUF_WORDS - 1)));
    assign w_in_pack   = (r_state == ST_PACK) & ~py_start_p;
    assign w_take      = w_in_pack & py_byte_valid_p & ~w_full;
    assign w_drop      = w_in_pack & py_byte_valid_p & w_full;
    assign w_end       = w_in_pack & py_end_p;
    assign w_lane_nxt  = w_take ? r_lane + 2'd1 : r_lane;
    assign w_word_done = w_take & (r_lane == 2'd3);
    assign w_flush     = w_end & (w_lane_nxt != 2'd0);

    always_comb begin
        w_pack_merged = r_pack;
        if (w_take) begin
            w_pack_merged[{r_lane, 3'b000} +: 8] = py_byte;
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (py_start_p) begin
            w_state_nxt = ST_PACK;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_IDLE;
                ST_PACK:  if (w_end) w_state_nxt = w_flush ? ST_FLUSH : ST_IDLE;
                ST_FLUSH: w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            r_pack    <= '0;
            r_lane    <= '0;
            r_addr    <= '0;
            r_din     <= '0;
            r_we      <= 1'b0;
            r_bytecnt <= '0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            if (py_start_p) begin
                r_pack    <= '0;
                r_lane    <= '0;
                r_addr    <= '0;
                r_bytecnt <= '0;
                r_ovf     <= 1'b0;
            end else begin
                if (r_we && !r_addr[ADDR_W]) begin
                    r_addr <= r_addr + 1'b1;
                end
                if (w_take && (r_bytecnt != BYTECNT_MAX)) begin
                    r_bytecnt <= r_bytecnt + 10'd1;
                end
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end
                r_lane <= w_end ? 2'd0 : w_lane_nxt;
                if (w_word_done || w_flush) begin
                    r_we   <= 1'b1;
                    r_din  <= w_pack_merged;
                    r_pack <= '0;
                end else begin
                    r_pack <= w_pack_merged;
                end
                if (w_end) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    // Once the buffer is exhausted the address parks on the last word instead of wrapping.
    assign lnctrl_addr = r_addr[ADDR_W] ? {ADDR_W{1'b1}} : r_addr[ADDR_W-1:0];
    assign lnctrl_din  = r_din;
    assign lnctrl_we   = r_we;
    assign py_bytecnt  = r_bytecnt;
    assign py_done_p   = r_done;
    assign py_ovf      = r_ovf;

endmodule

// File: tb/tb_pyrx_word_packer.sv
// tb/tb_pyrx_word_packer.sv - self-checking bench for pyrx_word_packer against a byte-list reference model
module tb_pyrx_word_packer;

    localparam int BUF = 256;
    localparam int AW  = 8;

    logic          clk_6M = 1'b0;
    logic          rstz;
    logic          py_start_p;
    logic [7:0]    py_byte;
    logic          py_byte_valid_p;
    logic          py_end_p;
    logic [AW-1:0] lnctrl_addr;
    logic [31:0]   lnctrl_din;
    logic          lnctrl_we;
    logic [9:0]    py_bytecnt;
    logic          py_done_p;
    logic          py_ovf;

    pyrx_word_packer #(.BUF_WORDS(BUF), .ADDR_W(AW)) dut (
        .clk_6M          (clk_6M),
        .rstz            (rstz),
        .py_start_p      (py_start_p),
        .py_byte         (py_byte),
        .py_byte_valid_p (py_byte_valid_p),
        .py_end_p        (py_end_p),
        .lnctrl_addr     (lnctrl_addr),
        .lnctrl_din      (lnctrl_din),
        .lnctrl_we       (lnctrl_we),
        .py_bytecnt      (py_bytecnt),
        .py_done_p       (py_done_p),
        .py_ovf          (py_ovf)
    );

    always #5 clk_6M = ~clk_6M;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          wq_addr[$];
    logic [31:0] wq_din[$];
    int          wq_cyc[$];
    int          done_cnt;
    int          done_cyc;
    int          end_cyc;
    logic [7:0]  pl[$];

    always @(posedge clk_6M) cyc <= cyc + 1;

    always @(negedge clk_6M) begin
        if (lnctrl_we === 1'b1) begin
            wq_addr.push_back(int'(lnctrl_addr));
            wq_din.push_back(lnctrl_din);
            wq_cyc.push_back(cyc);
        end
        if (py_done_p === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_6M);
        #1;
        py_start_p      = 1'b0;
        py_byte_valid_p = 1'b0;
        py_end_p        = 1'b0;
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_din.delete();
        wq_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    // Drives start, the bytes in pl with gaps in [glo,ghi], then end; checks against the model.
    task automatic run_payload(input int glo, input int ghi, input bit end_last,
                               input int eg, input string tag);
        int          n_acc;
        int          nw;
        logic [31:0] w;
        bit          last_on_end;
        clear_mon();
        tick();
        py_start_p = 1'b1;
        for (int i = 0; i < pl.size(); i++) begin
            repeat ($urandom_range(ghi, glo)) tick();
            tick();
            py_byte_valid_p = 1'b1;
            py_byte         = pl[i];
            if (end_last && i == pl.size() - 1) begin
                py_end_p = 1'b1;
                end_cyc  = cyc;
            end
        end
        if (!end_last || pl.size() == 0) begin
            repeat (eg) tick();
            tick();
            py_end_p = 1'b1;
            end_cyc  = cyc;
        end
        repeat (4) tick();

        n_acc = (pl.size() > 4 * BUF) ? 4 * BUF : pl.size();
        nw    = (n_acc + 3) / 4;
        chk({tag, "_nwr"}, wq_addr.size(), nw);
        for (int k = 0; k < nw && k < wq_addr.size(); k++) begin
            w = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < n_acc) w[8*j +: 8] = pl[4*k + j];
            end
            chk({tag, "_addr"}, wq_addr[k], k);
            chk({tag, "_din"}, wq_din[k], w);
        end
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_done_cyc"}, done_cyc, end_cyc + 1);
        last_on_end = (n_acc % 4 != 0) ||
                      (end_last && pl.size() > 0 && pl.size() <= 4 * BUF);
        if (last_on_end && wq_cyc.size() > 0) begin
            chk({tag, "_lastwr_cyc"}, wq_cyc[wq_cyc.size()-1], end_cyc + 1);
        end
        chk({tag, "_bytecnt"}, py_bytecnt, (n_acc > 1023) ? 1023 : n_acc);
        chk({tag, "_ovf"}, py_ovf, pl.size() > 4 * BUF);
        chk({tag, "_addr_final"}, lnctrl_addr, (nw >= BUF) ? BUF - 1 : nw);
        chk({tag, "_we_idle"}, lnctrl_we, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rstz            = 1'b0;
        py_start_p      = 1'b0;
        py_byte         = 8'h00;
        py_byte_valid_p = 1'b0;
        py_end_p        = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk_6M);
        #1;
        chk("rst_we", lnctrl_we, 1'b0);
        chk("rst_din", lnctrl_din, 32'h0);
        chk("rst_addr", lnctrl_addr, 8'h0);
        chk("rst_bytecnt", py_bytecnt, 10'h0);
        chk("rst_done", py_done_p, 1'b0);
        chk("rst_ovf", py_ovf, 1'b0);
        tick();
        rstz = 1'b1;
        tick();

        // end while idle must not produce a done pulse
        clear_mon();
        tick();
        py_end_p = 1'b1;
        repeat (3) tick();
        chk("idle_end_done", done_cnt, 0);

        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_payload(0, 0, 1'b1, 0, "t031");
        if (wq_din.size() > 0) chk("t031_const", wq_din[0], 32'h04030201);

        pl = '{8'hAA, 8'hBB, 8'hCC};
        run_payload(4, 4, 1'b0, 2, "t032");
        if (wq_din.size() > 0) chk("t032_const", wq_din[0], 32'h00CCBBAA);

        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'(i));
        run_payload(0, 0, 1'b0, 0, "t033");
        if (wq_din.size() == 3) chk("t033_const", wq_din[2], 32'h00000008);

        // restart mid-word: the two stray bytes must never be written
        tick();
        py_start_p = 1'b1;
        tick();
        py_byte_valid_p = 1'b1;
        py_byte         = 8'h99;
        tick();
        py_byte_valid_p = 1'b1;
        py_byte         = 8'h98;
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_payload(0, 0, 1'b1, 0, "t035");
        if (wq_din.size() > 0) chk("t035_const", wq_din[0], 32'h44332211);

        // start and end together: start wins, bytes that follow are packed
        clear_mon();
        tick();
        py_start_p = 1'b1;
        py_end_p   = 1'b1;
        tick();
        tick();
        py_byte_valid_p = 1'b1;
        py_byte         = 8'h5A;
        tick();
        py_byte_valid_p = 1'b1;
        py_byte         = 8'h6B;
        py_end_p        = 1'b1;
        end_cyc         = cyc;
        repeat (3) tick();
        chk("se_done_cnt", done_cnt, 1);
        chk("se_done_cyc", done_cyc, end_cyc + 1);
        chk("se_nwr", wq_din.size(), 1);
        if (wq_din.size() > 0) chk("se_din", wq_din[0], 32'h00006B5A);

        pl.delete();
        for (int i = 0; i < 1025; i++) pl.push_back(8'($urandom));
        run_payload(0, 0, 1'b1, 0, "t034");
        if (wq_addr.size() > 0) chk("t034_last_addr", wq_addr[wq_addr.size()-1], BUF - 1);

        for (int r = 0; r < 8; r++) begin
            pl.delete();
            for (int i = 0; i < int'($urandom_range(0, 40)); i++) pl.push_back(8'($urandom));
            run_payload(0, 3, 1'($urandom_range(0, 1)), $urandom_range(0, 3), "rnd");
        end

        // reset mid-payload aborts everything from that point on
        tick();
        py_start_p = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            py_byte_valid_p = 1'b1;
            py_byte         = 8'(8'hC0 + i);
        end
        tick();
        rstz = 1'b0;
        #2;
        clear_mon();
        chk("t036_we", lnctrl_we, 1'b0);
        chk("t036_din", lnctrl_din, 32'h0);
        chk("t036_addr", lnctrl_addr, 8'h0);
        chk("t036_bytecnt", py_bytecnt, 10'h0);
        chk("t036_ovf", py_ovf, 1'b0);
        tick();
        rstz = 1'b1;
        tick();
        py_end_p = 1'b1;
        tick();
        py_byte_valid_p = 1'b1;
        py_byte         = 8'hEE;
        repeat (4) tick();
        chk("t036_nwr", wq_din.size(), 0);
        chk("t036_done", done_cnt, 0);
        chk("t036_bytecnt_after", py_bytecnt, 10'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
